// File: rtl/video_clk_pkg.sv
// Shared definitions for the pixel-clock domain: lock-controller state and
// default MMCM sequencing constants, also used by the video timing blocks.
package video_clk_pkg;

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    WAIT_LOCK  = 3'd1,
    SETTLE     = 3'd2,
    RUNNING    = 3'd3,
    FAULT      = 3'd4
  } state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 100000;  // 1 ms at 100 MHz
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for slow level signals (locked, vsync)
// entering the clk domain. Flops clear on synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_lock_ctrl.sv
// MMCM reset sequencer and lock supervisor: pulses mmcm_rst, qualifies the
// synchronized LOCKED over a settle window, then releases the video pipeline.
module clk_lock_ctrl
  import video_clk_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       mmcm_rst,
  output logic       clocks_ok,
  output logic       pix_rst,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lost_lock_cnt,
  output state_e     state_dbg
);

  // Handshake with the clock generator: mmcm_rst high requests a reset; the
  // generator answers with locked, which is trusted only after crossing the
  // synchronizer and staying high for SETTLE_CYCLES consecutive cycles.

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       retry_nxt;
  logic [7:0]       lost_nxt;
  logic             locked_s;
  logic             mmcm_rst_nxt, clocks_ok_nxt, fault_nxt;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    lost_nxt  = lost_lock_cnt;

    if (relock_req) begin
      state_nxt = RST_ASSERT;
      cnt_nxt   = '0;
      retry_nxt = 2'd0;
    end else begin
      case (state)
        RST_ASSERT: begin
          if (cnt == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // A lock arriving on the timeout cycle takes precedence
          if (locked_s) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nxt = retry_cnt + 2'd1;
            state_nxt = (retry_nxt == RETRY_LIMIT) ? FAULT : RST_ASSERT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_nxt = RUNNING;
            cnt_nxt   = '0;
            retry_nxt = 2'd0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RUNNING: begin
          if (!locked_s) begin
            state_nxt = RST_ASSERT;
            cnt_nxt   = '0;
            if (lost_lock_cnt != 8'hFF) lost_nxt = lost_lock_cnt + 8'd1;
          end
        end
        FAULT: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = RST_ASSERT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they track state
  always_comb begin
    mmcm_rst_nxt  = (state_nxt == RST_ASSERT) || (state_nxt == FAULT);
    clocks_ok_nxt = (state_nxt == RUNNING);
    fault_nxt     = (state_nxt == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RST_ASSERT;
      cnt           <= '0;
      retry_cnt     <= 2'd0;
      lost_lock_cnt <= 8'd0;
      mmcm_rst      <= 1'b1;
      clocks_ok     <= 1'b0;
      pix_rst       <= 1'b1;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_cnt     <= retry_nxt;
      lost_lock_cnt <= lost_nxt;
      mmcm_rst      <= mmcm_rst_nxt;
      clocks_ok     <= clocks_ok_nxt;
      pix_rst       <= ~clocks_ok_nxt;
      fault         <= fault_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_clk_lock_ctrl.sv
// Randomized scoreboard bench for clk_lock_ctrl against a phase/timestamp
// reference model of the lock-sequencing rules.
module tb_clk_lock_ctrl;
  import video_clk_pkg::*;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 50;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 3;
  localparam int W             = 14;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       mmcm_rst, clocks_ok, pix_rst, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lost_lock_cnt;
  state_e     state_dbg;

  always #5 clk = ~clk;

  clk_lock_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .relock_req    (relock_req),
    .mmcm_rst      (mmcm_rst),
    .clocks_ok     (clocks_ok),
    .pix_rst       (pix_rst),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lost_lock_cnt (lost_lock_cnt),
    .state_dbg     (state_dbg)
  );

  // ---------------- reference model ----------------
  // Phases with entry timestamps; elapsed time is cycle minus entry cycle.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_SETTLE = 2, PH_RUN = 3, PH_FAULT = 4;
  int   m_phase = PH_PULSE;
  int   m_t0    = 0;
  int   m_cyc   = 0;
  int   m_retry = 0;
  int   m_lost  = 0;
  logic lk_hist [2] = '{1'b0, 1'b0};  // locked as seen 1 and 2 edges ago

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic enter(input int ph);
    m_phase = ph;
    m_t0    = m_cyc + 1;
  endtask

  task automatic model_step(input logic r, input logic lk, input logic rq);
    logic ls;
    int   el;
    ls = lk_hist[1];
    el = m_cyc - m_t0;
    if (r) begin
      enter(PH_PULSE);
      m_retry = 0;
      m_lost  = 0;
      lk_hist[0] = 1'b0;
      lk_hist[1] = 1'b0;
    end else begin
      if (rq) begin
        enter(PH_PULSE);
        m_retry = 0;
      end else if (m_phase == PH_PULSE) begin
        if (el == RST_CYCLES - 1) enter(PH_WAIT);
      end else if (m_phase == PH_WAIT) begin
        if (ls) enter(PH_SETTLE);
        else if (el == LOCK_TIMEOUT - 1) begin
          m_retry++;
          enter((m_retry == MAX_RETRIES) ? PH_FAULT : PH_PULSE);
        end
      end else if (m_phase == PH_SETTLE) begin
        if (!ls) enter(PH_WAIT);
        else if (el == SETTLE_CYCLES - 1) begin
          enter(PH_RUN);
          m_retry = 0;
        end
      end else if (m_phase == PH_RUN) begin
        if (!ls) begin
          enter(PH_PULSE);
          if (m_lost < 255) m_lost++;
        end
      end
      lk_hist[1] = lk_hist[0];
      lk_hist[0] = lk;
    end
    m_cyc++;
  endtask

  function automatic logic [W-1:0] model_out();
    logic run;
    run = (m_phase == PH_RUN);
    return {(m_phase == PH_PULSE) || (m_phase == PH_FAULT), run, ~run,
            (m_phase == PH_FAULT), 2'(m_retry), 8'(m_lost)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic lk, input logic rq);
    @(negedge clk);
    rst        = r;
    locked     = lk;
    relock_req = rq;
    model_step(r, lk, rq);
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input int n, input logic lk);
    for (int i = 0; i < n; i++) drive(1'b0, lk, 1'b0);
  endtask

  task automatic check_reset_state(input string name);
    @(posedge clk);
    #2;
    tests++;
    if (state_dbg !== RST_ASSERT || mmcm_rst !== 1'b1 || clocks_ok !== 1'b0) begin
      fails++;
      $display("FAIL %s: state=%0d mmcm_rst=%b clocks_ok=%b, required state=%0d mmcm_rst=1 clocks_ok=0",
               name, state_dbg, mmcm_rst, clocks_ok, RST_ASSERT);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {mmcm_rst, clocks_ok, pix_rst, fault, retry_cnt, lost_lock_cnt};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL outputs @%0t: got mmcm_rst=%b ok=%b pix_rst=%b fault=%b retry=%0d lost=%0d, required mmcm_rst=%b ok=%b pix_rst=%b fault=%b retry=%0d lost=%0d",
                   $time, act_v[13], act_v[12], act_v[11], act_v[10], act_v[9:8], act_v[7:0],
                   exp_v[13], exp_v[12], exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic lk;
    // Power-up reset, then lock 10 cycles after release
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    check_reset_state("reset_state");
    hold(10, 1'b0);
    hold(30, 1'b1);

    // Lock timeouts into FAULT, hold, then relock_req recovers
    drive(1'b1, 1'b0, 1'b0);
    hold(3 * (RST_CYCLES + LOCK_TIMEOUT) + 20, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    hold(12, 1'b0);

    // Glitch on locked during the settle window
    drive(1'b1, 1'b0, 1'b0);
    hold(8, 1'b1);
    hold(3, 1'b0);
    hold(25, 1'b1);

    // Lock losses while running, enough to saturate the loss counter
    for (int n = 0; n < 300; n++) begin
      hold($urandom_range(1, 6), 1'b0);
      hold($urandom_range(20, 30), 1'b1);
    end

    // relock_req on the second timeout cycle (retry_cnt already 1)
    drive(1'b1, 1'b0, 1'b0);
    hold(2 * (RST_CYCLES + LOCK_TIMEOUT) - 1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    hold(10, 1'b0);

    // rst mid-settle and mid-running
    drive(1'b1, 1'b0, 1'b0);
    hold(12, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check_reset_state("rst_mid_settle");
    hold(30, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check_reset_state("rst_mid_running");

    // Random lock behaviour with occasional relock requests
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      drive(1'b0, lk, ($urandom_range(0, 79) == 0));
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_lock_ctrl.md
Name: clk_lock_ctrl

Overview:
- Reset-sequencing and lock-supervision controller for the pixel-clock MMCM; runs on the free-running 100 MHz board clock.
- Drives the MMCM reset pulse, waits for the asynchronous LOCKED output, qualifies it over a settle window, then releases the video pipeline.
- On lock loss, it re-sequences the MMCM. After repeated lock timeouts, it declares a fault.
- Provides the rst/locked handshake for the clock generator.

Parameters:
- RST_CYCLES, 16, cycles mmcm_rst is held high per reset pulse (>=1).
- LOCK_TIMEOUT, 100000, cycles allowed in WAIT_LOCK before a retry (1 ms at 100 MHz).
- SETTLE_CYCLES, 1024, consecutive synchronized-locked cycles required before RUNNING.
- MAX_RETRIES, 3, lock timeouts tolerated before FAULT (>=1).
- CNT_W, $clog2(LOCK_TIMEOUT+1), width of the shared cycle counter. Must also cover RST_CYCLES and SETTLE_CYCLES.

Ports:
- clk  in  1  free-running system clock.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  MMCM LOCKED; asynchronous to clk.
- relock_req  in  1  single-cycle request to re-sequence the MMCM (e.g. mode change).
- mmcm_rst  out  1  MMCM reset, active-high.
- clocks_ok  out  1  high only in RUNNING.
- pix_rst  out  1  reset for the video pipeline; equals ~clocks_ok.
- fault  out  1  high only in FAULT.
- retry_cnt  out  2  lock timeouts since the last successful lock.
- lost_lock_cnt  out  8  saturating count of lock losses in RUNNING.

Behaviour:
- Synchronizer: locked passes through a 2-flop synchronizer to give locked_s. This adds 2 cycles of latency; all decisions use locked_s only.
- Outputs: all outputs are registered and decoded from the state register.
- Reset values (rst=1 at a clock edge):
  - state=RST_ASSERT, counter=0.
  - mmcm_rst=1, clocks_ok=0, pix_rst=1, fault=0.
  - retry_cnt=0, lost_lock_cnt=0.
  - Synchronizer flops cleared.
  - A mid-operation rst has the same effect from any state.
- States:
  - RST_ASSERT:
    - Outputs: mmcm_rst=1.
    - Counter counts 0..RST_CYCLES-1, so mmcm_rst is high for exactly RST_CYCLES cycles.
    - Next: WAIT_LOCK, with counter=0.
  - WAIT_LOCK:
    - Outputs: mmcm_rst=0.
    - If locked_s=1: go to SETTLE, counter=0.
    - Else, when counter reaches LOCK_TIMEOUT-1: increment retry_cnt.
      - If the new value equals MAX_RETRIES: go to FAULT.
      - Otherwise: go to RST_ASSERT.
    - If locked_s rises on the same cycle as the timeout, locked_s wins.
  - SETTLE:
    - Outputs: mmcm_rst=0.
    - If locked_s=0: return to WAIT_LOCK with counter=0. retry_cnt is unchanged; the timeout window restarts.
    - After SETTLE_CYCLES consecutive cycles: go to RUNNING and clear retry_cnt.
  - RUNNING:
    - Outputs: clocks_ok=1, pix_rst=0.
    - If locked_s=0: go to RST_ASSERT and increment lost_lock_cnt (saturates at 255).
  - FAULT:
    - Outputs: mmcm_rst=1, fault=1, pix_rst=1.
    - Holds indefinitely; the only exits are relock_req or rst.
- relock_req:
  - Highest priority after rst; acts in every state.
  - Next state RST_ASSERT, counter=0, retry_cnt=0, fault drops next cycle.
  - Overrides a simultaneous timeout or lock loss: no retry or lost-lock increment that cycle.
  - Asserted during RST_ASSERT, it restarts the pulse count.
- Lock timing: pix_rst deasserts no earlier than 2 + SETTLE_CYCLES cycles after locked rises.
- Counter: one shared CNT_W-bit counter, zeroed on every state transition. It never wraps because every state exits at its terminal value.

Decomposition:
- Package video_clk_pkg:
  - state enum (RST_ASSERT, WAIT_LOCK, SETTLE, RUNNING, FAULT).
  - Default timing constants.
  - Shared with the video timing blocks.
- Sub-module sync_2ff: single-bit 2-flop synchronizer, reused elsewhere for locked/vsync crossings.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=8, MAX_RETRIES=3.
1. Power-up, then rst released, with locked raised 10 cycles later → mmcm_rst high exactly 4 cycles; clocks_ok rises 2+8 cycles after locked; retry_cnt=0.
2. locked held low → 3 pulses of mmcm_rst (4 cycles each), spaced by 50-cycle waits; retry_cnt reaches 3; fault=1 and mmcm_rst=1 held. A subsequent relock_req → fault=0, retry_cnt=0, new 4-cycle pulse.
3. locked glitches low for 3 cycles at SETTLE cycle 5 → return to WAIT_LOCK; clocks_ok stays 0; retry_cnt unchanged. A stable locked → RUNNING 10 cycles after re-rise.
4. In RUNNING, locked drops → clocks_ok falls 3 cycles later (2 sync + 1 register); lost_lock_cnt 0→1; mmcm_rst pulses 4 cycles. Repeat 300 losses → lost_lock_cnt saturates at 255.
5. relock_req on the same cycle as the WAIT_LOCK timeout (retry_cnt=1) → RST_ASSERT with retry_cnt=0, not 2.
6. rst asserted mid-SETTLE and mid-RUNNING → next cycle state=RST_ASSERT, mmcm_rst=1, clocks_ok=0, counters cleared.
